// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction controller:
// state encoding, coin values and the selection price table.
package vend_pkg;

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_COLLECT  = 3'd1,
      S_DISPENSE = 3'd2,
      S_CHANGE   = 3'd3,
      S_REFUND   = 3'd4
   } vend_state_t;

   localparam int unsigned COIN_5  = 5;
   localparam int unsigned COIN_10 = 10;
   localparam int unsigned COIN_25 = 25;

   localparam int unsigned PRICE_15 = 15;
   localparam int unsigned PRICE_20 = 20;
   localparam int unsigned PRICE_25 = 25;
   localparam int unsigned PRICE_30 = 30;

   // Lowest set switch wins; no switch means no product (price 0).
   function automatic int unsigned sel_to_price(input logic [3:0] s);
      if (s[0])      return PRICE_15;
      else if (s[1]) return PRICE_20;
      else if (s[2]) return PRICE_25;
      else if (s[3]) return PRICE_30;
      else           return 0;
   endfunction

   function automatic logic [3:0] sel_onehot(input logic [3:0] s);
      return s & (~s + 4'd1);
   endfunction

   function automatic int unsigned coin_value(input logic [2:0] g);
      if (g[2])      return COIN_25;
      else if (g[1]) return COIN_10;
      else if (g[0]) return COIN_5;
      else           return 0;
   endfunction

endpackage

// File: rtl/coin_arbiter.sv
// Holds one pending flag per coin type and grants the highest-value pending
// coin (quarter > dime > nickel) when enabled; a flag clears once resolved.
module coin_arbiter #(
   parameter int CREDIT_W = 8
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic [2:0]          coin_req,
   input  logic                grant_en,
   input  logic                accept,
   input  logic                reject,
   output logic [2:0]          grant,
   output logic                grant_valid,
   output logic [CREDIT_W-1:0] grant_val
);
   import vend_pkg::*;

   logic [2:0] pending;

   always_comb begin
      grant = 3'b000;
      if (grant_en) begin
         if (pending[2])      grant = 3'b100;
         else if (pending[1]) grant = 3'b010;
         else if (pending[0]) grant = 3'b001;
      end
   end

   assign grant_valid = |grant;
   assign grant_val   = CREDIT_W'(coin_value(grant));

   // A new request in the same cycle as its grant re-arms the flag.
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~(grant & {3{accept | reject}})) | coin_req;
      end
   end

endmodule

// File: rtl/vend_sequencer.sv
// Vending transaction controller: coin credit, purchase, dispense and
// nickel-paced change/refund. Optional idle auto-refund under VEND_TIMEOUT_EN.
module vend_sequencer #(
   parameter int CREDIT_W      = 8,
   parameter int MAX_CREDIT    = 35,
   parameter int TIMEOUT_TICKS = 30
) (
   input  logic                clk,
   input  logic                clr_n,
   input  logic                tick,
   input  logic [2:0]          coin_req,
   input  logic [3:0]          sel,
   input  logic                buy,
   input  logic                cancel,
   output logic [2:0]          coin_ack,
   output logic                coin_reject,
   output logic [CREDIT_W-1:0] credit,
   output logic [CREDIT_W-1:0] price,
   output logic                dispense,
   output logic [3:0]          vend_led,
   output logic                change_nickel,
   output logic                insufficient,
   output logic                busy
);
   import vend_pkg::*;

   localparam logic [CREDIT_W-1:0] NICKEL = CREDIT_W'(COIN_5);
   localparam logic [CREDIT_W:0]   MAX_C  = (CREDIT_W+1)'(MAX_CREDIT);

   vend_state_t         state;
   logic [CREDIT_W-1:0] price_lat;
   logic [3:0]          led_lat;
   logic [2:0]          grant;
   logic                grant_valid;
   logic [CREDIT_W-1:0] grant_val;
   logic [CREDIT_W:0]   credit_sum;
   logic                in_entry, do_cancel, buy_eff, buy_ok, buy_short;
   logic                grant_en, fits, accept, reject, tmo_fire;

   assign price      = CREDIT_W'(sel_to_price(sel));
   assign in_entry   = (state == S_IDLE) || (state == S_COLLECT);
   assign do_cancel  = (state == S_COLLECT) && cancel;
   assign buy_eff    = in_entry && buy && (price != '0) && !do_cancel;
   assign buy_ok     = buy_eff && (credit >= price);
   assign buy_short  = buy_eff && (credit < price);
   // Cancel and purchase outrank coin grants; an ungranted coin stays pending.
   assign grant_en   = in_entry && !do_cancel && !buy_eff;
   assign credit_sum = {1'b0, credit} + {1'b0, grant_val};
   assign fits       = credit_sum <= MAX_C;
   assign accept     = grant_valid && fits;
   assign reject     = grant_valid && !fits;

   coin_arbiter #(.CREDIT_W(CREDIT_W)) u_arb (
      .clk         (clk),
      .clr_n       (clr_n),
      .coin_req    (coin_req),
      .grant_en    (grant_en),
      .accept      (accept),
      .reject      (reject),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_val   (grant_val)
   );

`ifdef VEND_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_TICKS + 1);

   logic [TW-1:0] idle_ticks;
   logic          activity;

   assign activity = grant_valid || buy_eff;
   assign tmo_fire = (state == S_COLLECT) && tick && !activity && !do_cancel &&
                     (idle_ticks == TW'(TIMEOUT_TICKS - 1));

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         idle_ticks <= '0;
      end else if ((state != S_COLLECT) || activity || tmo_fire) begin
         idle_ticks <= '0;
      end else if (tick) begin
         idle_ticks <= idle_ticks + TW'(1);
      end
   end
`else
   logic unused_timeout_cfg;

   assign tmo_fire           = 1'b0;
   assign unused_timeout_cfg = ^TIMEOUT_TICKS;
`endif

   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state         <= S_IDLE;
         credit        <= '0;
         coin_ack      <= '0;
         coin_reject   <= 1'b0;
         dispense      <= 1'b0;
         vend_led      <= '0;
         change_nickel <= 1'b0;
         insufficient  <= 1'b0;
         busy          <= 1'b0;
         price_lat     <= '0;
         led_lat       <= '0;
      end else begin
         coin_ack      <= '0;
         coin_reject   <= 1'b0;
         dispense      <= 1'b0;
         change_nickel <= 1'b0;
         insufficient  <= 1'b0;
         case (state)
            S_IDLE, S_COLLECT: begin
               if (do_cancel || tmo_fire) begin
                  state <= S_REFUND;
                  busy  <= 1'b1;
               end else if (buy_ok) begin
                  // Selection and price are frozen here for the whole transaction.
                  state     <= S_DISPENSE;
                  busy      <= 1'b1;
                  dispense  <= 1'b1;
                  price_lat <= price;
                  led_lat   <= sel_onehot(sel);
               end else if (buy_short) begin
                  insufficient <= 1'b1;
               end else if (accept) begin
                  credit   <= credit_sum[CREDIT_W-1:0];
                  coin_ack <= grant;
                  state    <= S_COLLECT;
               end else if (reject) begin
                  coin_reject <= 1'b1;
               end
            end
            S_DISPENSE: begin
               credit   <= credit - price_lat;
               vend_led <= led_lat;
               if (credit == price_lat) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else begin
                  state <= S_CHANGE;
               end
            end
            S_CHANGE, S_REFUND: begin
               if (credit == '0) begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end else if (tick) begin
                  change_nickel <= 1'b1;
                  credit        <= credit - NICKEL;
               end
            end
            default: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
